tone_pwm_synth: RTL and testbench

//  Two-voice tone synthesizer driving the board's mono PWM audio pin (AUD_PWM; AUD_SD tied high at top level).

---
 rtl/tone_pwm_synth.sv | 166 ++++++++++++++++
 tb/tb_tone_pwm_synth.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tone_pwm_synth.sv
// -----------------------------------------------------------------------------
// tone_pwm_synth
//   Two-voice triangle-wave tone synthesizer with a decaying amplitude
//   envelope, rendered as 8-bit PWM on a single audio pin.
//
//   Each voice owns a 32-bit phase accumulator advanced every clock by an
//   increment looked up from a constant 32-entry semitone table. The two
//   triangle waves are averaged, scaled by the envelope and latched into the
//   PWM duty register once per 256-clock PWM period.
//
// Parameters
//   CLK_HZ        clock frequency in Hz (only used to build the pitch table)
//   BASE_HZ       pitch of semitone index 0 in Hz
//   DECAY_CYCLES  clocks per envelope decrement step
//   SUSTAIN       envelope floor reached after a note has decayed (0..255)
//
// Ports
//   clock     in   1  system clock, all logic on posedge
//   reset     in   1  synchronous, active-high; silences the output
//   freq_id1  in   5  voice 1 semitone index
//   freq_id2  in   5  voice 2 semitone index
//   new_f     in   1  one-cycle trigger: latch ids, restart phases,
//                     retrigger the envelope
//   pwm       out  1  registered PWM audio output
// -----------------------------------------------------------------------------
module tone_pwm_synth #(
    parameter int CLK_HZ       = 65_000_000,
    parameter int BASE_HZ      = 110,
    parameter int DECAY_CYCLES = 65_000,
    parameter int SUSTAIN      = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] freq_id1,
    input  logic [4:0] freq_id2,
    input  logic       new_f,
    output logic       pwm
);

    localparam logic [31:0] TIMER_LAST  = 32'(DECAY_CYCLES - 1);
    localparam logic [7:0]  SUSTAIN_LVL = 8'(SUSTAIN);

    // 2^(k/12) for k = 0..11, scaled by 1e12. Twelve decimal places keep the
    // table error far below the rounding step of any realistic increment.
    function automatic logic [63:0] semitone_ratio(input int k);
        logic [63:0] r;
        case (k)
            0:       r = 64'd1000000000000;
            1:       r = 64'd1059463094359;
            2:       r = 64'd1122462048309;
            3:       r = 64'd1189207115003;
            4:       r = 64'd1259921049895;
            5:       r = 64'd1334839854170;
            6:       r = 64'd1414213562373;
            7:       r = 64'd1498307076877;
            8:       r = 64'd1587401051968;
            9:       r = 64'd1681792830507;
            10:      r = 64'd1781797436281;
            default: r = 64'd1887748625363;
        endcase
        return r;
    endfunction

    // inc(id) = round(2^32 * BASE_HZ * 2^(id/12) / CLK_HZ), evaluated at
    // elaboration with wide integer arithmetic. The octave part of the
    // exponent becomes an extra left shift.
    function automatic logic [31:0] calc_inc(input int id);
        logic [95:0] num;
        logic [95:0] den;
        num = (96'(BASE_HZ) * 96'(semitone_ratio(id % 12))) << (32 + id / 12);
        den = 96'(CLK_HZ) * 96'(64'd1000000000000);
        return 32'((num + (den >> 1)) / den);
    endfunction

    logic [31:0] inc_rom [32];

    for (genvar gi = 0; gi < 32; gi++) begin : g_inc_rom
        assign inc_rom[gi] = calc_inc(gi);
    end

    // State
    logic [4:0]  id1_reg,    id1_next;
    logic [4:0]  id2_reg,    id2_next;
    logic [31:0] phase1_reg, phase1_next;
    logic [31:0] phase2_reg, phase2_next;
    logic [7:0]  env_reg,    env_next;
    logic [31:0] timer_reg,  timer_next;
    logic [7:0]  cnt_reg,    cnt_next;
    logic [7:0]  duty_reg,   duty_next;
    logic        pwm_reg,    pwm_next;

    // Datapath
    logic [7:0] wave1;
    logic [7:0] wave2;
    logic [7:0] mix;
    logic [7:0] amp;

    // Triangle: rising ramp in the first half of the phase, mirrored in the second.
    assign wave1 = phase1_reg[31] ? ~phase1_reg[30:23] : phase1_reg[30:23];
    assign wave2 = phase2_reg[31] ? ~phase2_reg[30:23] : phase2_reg[30:23];

    // 9-bit sum so the average cannot overflow.
    assign mix = 8'(({1'b0, wave1} + {1'b0, wave2}) >> 1);
    // With both factors at most 255 the product's top byte peaks at 254.
    assign amp = 8'(({8'd0, mix} * {8'd0, env_reg}) >> 8);

    always_comb begin
        id1_next    = id1_reg;
        id2_next    = id2_reg;
        phase1_next = phase1_reg + inc_rom[id1_reg];
        phase2_next = phase2_reg + inc_rom[id2_reg];
        env_next    = env_reg;
        timer_next  = timer_reg + 32'd1;
        cnt_next    = cnt_reg + 8'd1;
        duty_next   = duty_reg;
        // duty is constant for the whole period, so this is glitch-free.
        pwm_next    = (cnt_reg < duty_reg);

        // Duty only changes at the period boundary.
        if (cnt_reg == 8'hFF) begin
            duty_next = amp;
        end

        if (new_f) begin
            id1_next    = freq_id1;
            id2_next    = freq_id2;
            phase1_next = '0;
            phase2_next = '0;
            env_next    = 8'hFF;
            timer_next  = '0;
        end else if (timer_reg == TIMER_LAST) begin
            timer_next = '0;
            // After reset env is 0, below the floor, so it stays silent.
            if (env_reg > SUSTAIN_LVL) begin
                env_next = env_reg - 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            id1_reg    <= '0;
            id2_reg    <= '0;
            phase1_reg <= '0;
            phase2_reg <= '0;
            env_reg    <= '0;
            timer_reg  <= '0;
            cnt_reg    <= '0;
            duty_reg   <= '0;
            pwm_reg    <= 1'b0;
        end else begin
            id1_reg    <= id1_next;
            id2_reg    <= id2_next;
            phase1_reg <= phase1_next;
            phase2_reg <= phase2_next;
            env_reg    <= env_next;
            timer_reg  <= timer_next;
            cnt_reg    <= cnt_next;
            duty_reg   <= duty_next;
            pwm_reg    <= pwm_next;
        end
    end

    assign pwm = pwm_reg;

endmodule

// File: tb/tb_tone_pwm_synth.sv
// -----------------------------------------------------------------------------
// tb_tone_pwm_synth
//   Bench for tone_pwm_synth with a scaled-down clock rate and decay step so
//   that whole triangle periods and the full envelope decay fit in a short run.
//   A behavioural reference computes the duty expected for every PWM period
//   and queues it; the monitor counts the DUT's high cycles in each period and
//   compares against the queued value.
// -----------------------------------------------------------------------------
module tb_tone_pwm_synth;

    localparam int CLK_HZ  = 650_000;
    localparam int BASE_HZ = 110;
    localparam int DECAY   = 32;
    localparam int SUSTAIN = 64;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       new_f = 1'b0;
    logic [4:0] freq_id1 = '0;
    logic [4:0] freq_id2 = '0;
    logic       pwm;

    always #5 clock = ~clock;

    tone_pwm_synth #(
        .CLK_HZ      (CLK_HZ),
        .BASE_HZ     (BASE_HZ),
        .DECAY_CYCLES(DECAY),
        .SUSTAIN     (SUSTAIN)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .freq_id1(freq_id1),
        .freq_id2(freq_id2),
        .new_f   (new_f),
        .pwm     (pwm)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end else begin
            $display("[TB] ok %s: got %0d", tag, actual);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int inc_of(input int id);
        real r;
        r = 4294967296.0 * real'(BASE_HZ) * (2.0 ** (real'(id) / 12.0)) / real'(CLK_HZ);
        return $rtoi(r + 0.5);
    endfunction

    function automatic int wave_of(input logic [31:0] ph);
        int v;
        v = int'(ph[30:23]);
        return ph[31] ? 255 - v : v;
    endfunction

    logic [31:0] m_ph1, m_ph2, m_timer;
    logic [4:0]  m_id1, m_id2;
    int          m_env;
    logic [7:0]  m_cnt, m_duty;
    logic        m_after_rst = 1'b1;
    int          exp_q[$];

    always @(posedge clock) begin
        int a;
        a = (((wave_of(m_ph1) + wave_of(m_ph2)) / 2) * m_env) / 256;
        if (reset) begin
            m_ph1 <= '0; m_ph2 <= '0; m_timer <= '0;
            m_id1 <= '0; m_id2 <= '0; m_env <= 0;
            m_cnt <= '0; m_duty <= '0;
            m_after_rst <= 1'b1;
            // The period starting now runs with duty 0.
            exp_q.delete();
            exp_q.push_back(0);
        end else begin
            m_after_rst <= 1'b0;
            m_cnt <= m_cnt + 8'd1;
            if (m_cnt == 8'd255) begin
                m_duty <= 8'(a);
                exp_q.push_back(a);
            end
            if (new_f) begin
                m_id1 <= freq_id1; m_id2 <= freq_id2;
                m_ph1 <= '0; m_ph2 <= '0;
                m_env <= 255; m_timer <= '0;
            end else begin
                m_ph1 <= m_ph1 + 32'(inc_of(int'(m_id1)));
                m_ph2 <= m_ph2 + 32'(inc_of(int'(m_id2)));
                if (m_timer == 32'(DECAY - 1)) begin
                    m_timer <= '0;
                    if (m_env > SUSTAIN) m_env <= m_env - 1;
                end else begin
                    m_timer <= m_timer + 32'd1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    // A PWM period as seen on the pin spans the 256 samples that end when the
    // reference counter has just wrapped to 0.
    int acc     = 0;
    int win_max = 0;
    bit clr_max = 1'b0;

    always @(negedge clock) begin
        if (clr_max) begin
            win_max = 0;
            clr_max = 1'b0;
        end
        if (m_after_rst) begin
            acc = 0;
        end else begin
            acc += int'(pwm);
            if (m_cnt == 8'd0) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                end else begin
                    check("period_high_count", acc, exp_q.pop_front());
                end
                if (acc > win_max) win_max = acc;
                acc = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic trigger(input logic [4:0] a, input logic [4:0] b);
        @(negedge clock);
        freq_id1 = a;
        freq_id2 = b;
        new_f    = 1'b1;
        @(negedge clock);
        new_f    = 1'b0;
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        run(3);
        check("reset_pwm", int'(pwm), 0);
        reset = 1'b0;

        // T1: idle, ids wiggle without new_f -> silence
        for (int i = 0; i < 8; i++) begin
            freq_id1 = 5'($urandom_range(0, 31));
            freq_id2 = 5'($urandom_range(0, 31));
            run(250);
        end

        // T2: lowest pitch, one full triangle period
        trigger(5'd0, 5'd0);
        run(6000);

        // T3: one octave up
        trigger(5'd12, 5'd12);
        run(3500);

        // T4: let the envelope settle on the floor, then inspect a full period
        trigger(5'd0, 5'd0);
        run(7000);
        clr_max = 1'b1;
        run(6200);
        check("floor_max_le_63", int'(win_max <= 63), 1);
        check("floor_max_nonzero", int'(win_max > 0), 1);

        // T5: ids change without new_f, then a retrigger with new pitch
        trigger(5'd7, 5'd3);
        run(500);
        freq_id1 = 5'd20;
        freq_id2 = 5'd5;
        run(2500);
        trigger(5'd20, 5'd5);
        run(3000);

        // T6: reset mid-note together with new_f; reset wins
        trigger(5'd9, 5'd14);
        run(1000);
        reset = 1'b1;
        new_f = 1'b1;
        @(negedge clock);
        check("reset_mid_note_pwm", int'(pwm), 0);
        reset = 1'b0;
        new_f = 1'b0;
        run(2000);

        // Extremes and a few random pairs
        trigger(5'd31, 5'd31);
        run(2000);
        trigger(5'd0, 5'd31);
        run(2000);
        for (int i = 0; i < 3; i++) begin
            trigger(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            run(1500);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
